// File: rtl/serial_uart_bridge.sv
// serial_uart_bridge: processor byte handshake <-> UART line pair, with a small FIFO per direction.
// Default framing is 8N1; define SERIAL_PARITY_EN for 8E1 (even parity on both TX and RX).

module serial_uart_bridge_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head reads as zero while empty so the output is clean out of reset.
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end
endmodule

module serial_uart_bridge #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] proc_rx_data,
  output logic       proc_rx_valid,
  input  logic       proc_rx_rden,
  input  logic [7:0] proc_tx_data,
  input  logic       proc_tx_wren,
  output logic       proc_tx_ready,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic       rx_frame_err,
  output logic       rx_overflow
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef SERIAL_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // ---------------- TX ----------------
  state_t        tx_state, tx_state_nx;
  logic [CW-1:0] tx_cnt, tx_cnt_nx;
  logic [2:0]    tx_bit, tx_bit_nx;
  logic [7:0]    tx_shift, tx_shift_nx, tx_head;
  logic          tx_pop, tx_empty, tx_full, tx_tc;
`ifdef SERIAL_PARITY_EN
  logic          tx_par, tx_par_nx;
`endif

  serial_uart_bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock(clock), .reset(reset), .push(proc_tx_wren), .push_data(proc_tx_data),
    .pop(tx_pop), .head(tx_head), .empty(tx_empty), .full(tx_full)
  );

  assign proc_tx_ready = !tx_full;
  assign tx_tc         = (tx_cnt == CNT_LAST);

  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    tx_bit_nx   = tx_bit;
    tx_shift_nx = tx_shift;
    tx_pop      = 1'b0;
    uart_txd    = 1'b1;
`ifdef SERIAL_PARITY_EN
    tx_par_nx   = tx_par;
`endif
    if (tx_state != S_IDLE) tx_cnt_nx = tx_tc ? '0 : tx_cnt + 1'b1;
    case (tx_state)
      S_IDLE: if (!tx_empty) begin
        tx_pop      = 1'b1;
        tx_shift_nx = tx_head;
        tx_cnt_nx   = '0;
        tx_bit_nx   = '0;
`ifdef SERIAL_PARITY_EN
        tx_par_nx   = ^tx_head;
`endif
        tx_state_nx = S_START;
      end
      S_START: begin
        uart_txd = 1'b0;
        if (tx_tc) tx_state_nx = S_DATA;
      end
      S_DATA: begin
        uart_txd = tx_shift[0];
        if (tx_tc) begin
          tx_shift_nx = {1'b0, tx_shift[7:1]};
          tx_bit_nx   = tx_bit + 3'd1;
`ifdef SERIAL_PARITY_EN
          if (tx_bit == 3'd7) tx_state_nx = S_PARITY;
`else
          if (tx_bit == 3'd7) tx_state_nx = S_STOP;
`endif
        end
      end
`ifdef SERIAL_PARITY_EN
      S_PARITY: begin
        uart_txd = tx_par;
        if (tx_tc) tx_state_nx = S_STOP;
      end
`endif
      S_STOP: if (tx_tc) tx_state_nx = S_IDLE;
      default: tx_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
`ifdef SERIAL_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_bit   <= tx_bit_nx;
      tx_shift <= tx_shift_nx;
`ifdef SERIAL_PARITY_EN
      tx_par   <= tx_par_nx;
`endif
    end
  end

  // ---------------- RX ----------------
  state_t        rx_state, rx_state_nx;
  logic [CW-1:0] rx_cnt, rx_cnt_nx;
  logic [2:0]    rx_bit, rx_bit_nx;
  logic [7:0]    rx_shift, rx_shift_nx;
  logic          rxd_meta, rxd_s, rx_armed, rx_armed_nx;
  logic          rx_push, rx_full, rx_empty, rx_tc, rx_mid, rx_bad;
  logic          err_nx, ovf_nx;
`ifdef SERIAL_PARITY_EN
  logic          rx_par_bad, rx_par_bad_nx;
  assign rx_bad = !rxd_s || rx_par_bad;
`else
  assign rx_bad = !rxd_s;
`endif

  serial_uart_bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock(clock), .reset(reset), .push(rx_push), .push_data(rx_shift),
    .pop(proc_rx_rden), .head(proc_rx_data), .empty(rx_empty), .full(rx_full)
  );

  assign proc_rx_valid = !rx_empty;
  assign rx_tc         = (rx_cnt == CNT_LAST);
  assign rx_mid        = (rx_cnt == CNT_MID);

  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt;
    rx_bit_nx   = rx_bit;
    rx_shift_nx = rx_shift;
    rx_armed_nx = rx_armed | rxd_s;
    rx_push     = 1'b0;
    err_nx      = 1'b0;
    ovf_nx      = 1'b0;
`ifdef SERIAL_PARITY_EN
    rx_par_bad_nx = rx_par_bad;
`endif
    if (rx_state != S_IDLE) rx_cnt_nx = rx_tc ? '0 : rx_cnt + 1'b1;
    case (rx_state)
      S_IDLE: if (!rxd_s && rx_armed) begin
        rx_state_nx = S_START;
        rx_cnt_nx   = '0;
      end
      S_START: if (rx_mid) begin
        rx_cnt_nx   = '0;
        rx_bit_nx   = '0;
        rx_state_nx = rxd_s ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_tc) begin
        rx_shift_nx = {rxd_s, rx_shift[7:1]};
        rx_bit_nx   = rx_bit + 3'd1;
`ifdef SERIAL_PARITY_EN
        if (rx_bit == 3'd7) rx_state_nx = S_PARITY;
`else
        if (rx_bit == 3'd7) rx_state_nx = S_STOP;
`endif
      end
`ifdef SERIAL_PARITY_EN
      S_PARITY: if (rx_tc) begin
        rx_par_bad_nx = (^rx_shift) ^ rxd_s;
        rx_state_nx   = S_STOP;
      end
`endif
      S_STOP: if (rx_tc) begin
        // A low stop bit leaves the line low; wait for it to go high before re-arming.
        rx_state_nx = S_IDLE;
        rx_armed_nx = rxd_s;
        if (rx_bad)       err_nx  = 1'b1;
        else if (rx_full) ovf_nx  = 1'b1;
        else              rx_push = 1'b1;
      end
      default: rx_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rxd_meta     <= 1'b1;
      rxd_s        <= 1'b1;
      rx_state     <= S_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_armed     <= 1'b1;
      rx_frame_err <= 1'b0;
      rx_overflow  <= 1'b0;
`ifdef SERIAL_PARITY_EN
      rx_par_bad   <= 1'b0;
`endif
    end else begin
      rxd_meta     <= uart_rxd;
      rxd_s        <= rxd_meta;
      rx_state     <= rx_state_nx;
      rx_cnt       <= rx_cnt_nx;
      rx_bit       <= rx_bit_nx;
      rx_shift     <= rx_shift_nx;
      rx_armed     <= rx_armed_nx;
      rx_frame_err <= err_nx;
      rx_overflow  <= ovf_nx;
`ifdef SERIAL_PARITY_EN
      rx_par_bad   <= rx_par_bad_nx;
`endif
    end
  end
endmodule

// File: tb/tb_serial_uart_bridge.sv
// Self-checking bench for serial_uart_bridge with a queue-based UART reference model.
// Honours SERIAL_PARITY_EN (8E1 framing and the parity scenario) when defined.

module tb_serial_uart_bridge;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef SERIAL_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] proc_rx_data;
  logic       proc_rx_valid;
  logic       proc_rx_rden;
  logic [7:0] proc_tx_data;
  logic       proc_tx_wren;
  logic       proc_tx_ready;
  logic       uart_rxd;
  logic       uart_txd;
  logic       rx_frame_err;
  logic       rx_overflow;

  int tests_run = 0;
  int fails = 0;
  int err_pulses = 0, ovf_pulses = 0;
  int exp_err = 0, exp_ovf = 0;
  int tx_stop_bad = 0, tx_par_bad = 0;
  logic [7:0] tx_got[$];
  logic [7:0] rx_q[$];
  logic [7:0] mon_b;

  always #5 clock = ~clock;

  serial_uart_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .proc_rx_data(proc_rx_data), .proc_rx_valid(proc_rx_valid), .proc_rx_rden(proc_rx_rden),
    .proc_tx_data(proc_tx_data), .proc_tx_wren(proc_tx_wren), .proc_tx_ready(proc_tx_ready),
    .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .rx_frame_err(rx_frame_err), .rx_overflow(rx_overflow)
  );

  always @(negedge clock) begin
    if (rx_frame_err === 1'b1) err_pulses++;
    if (rx_overflow === 1'b1) ovf_pulses++;
  end

  // Passive UART receiver on uart_txd, sampling mid-bit.
  initial begin
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && uart_txd === 1'b0) begin
        repeat (CPB / 2) @(negedge clock);
        if (uart_txd === 1'b0) begin
          for (int k = 0; k < 8; k++) begin
            repeat (CPB) @(negedge clock);
            mon_b[k] = uart_txd;
          end
`ifdef SERIAL_PARITY_EN
          repeat (CPB) @(negedge clock);
          if (uart_txd !== ^mon_b) tx_par_bad++;
`endif
          repeat (CPB) @(negedge clock);
          if (uart_txd !== 1'b1) tx_stop_bad++;
          tx_got.push_back(mon_b);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  // Line level of bit slot j of a frame carrying b (start, data LSB first, [parity], stop).
  function automatic logic frame_bit(input logic [7:0] b, input int j, input logic par_flip);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
`ifdef SERIAL_PARITY_EN
    if (j == 9) return (^b) ^ par_flip;
`endif
    return 1'b1;
  endfunction

  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    for (int j = 0; j < NBITS; j++) begin
      @(negedge clock);
      uart_rxd = (j == NBITS - 1) ? stop_bit : frame_bit(b, j, par_flip);
      repeat (CPB - 1) @(negedge clock);
    end
    @(negedge clock);
    uart_rxd = 1'b1;
`ifdef SERIAL_PARITY_EN
    if (!stop_bit || par_flip) exp_err++;
`else
    if (!stop_bit) exp_err++;
`endif
    else if (rx_q.size() >= DEPTH) exp_ovf++;
    else rx_q.push_back(b);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    tests_run++;
    if ({uart_txd, proc_tx_ready, proc_rx_valid, proc_rx_data, rx_frame_err, rx_overflow} !== 13'b1_1_0_00000000_0_0) begin
      fails++;
      $display("FAIL reset_outputs: got txd=%b ready=%b valid=%b data=%h err=%b ovf=%b, required 1 1 0 00 0 0",
               uart_txd, proc_tx_ready, proc_rx_valid, proc_rx_data, rx_frame_err, rx_overflow);
    end
    reset = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      tests_run++;
      if ({uart_txd, proc_tx_ready, proc_rx_valid} !== 3'b110) begin
        fails++;
        $display("FAIL idle_cycle %0d: got txd/ready/valid=%b, required 110", c, {uart_txd, proc_tx_ready, proc_rx_valid});
      end
    end
  endtask

  task automatic test_tx_frame(input logic [7:0] b);
    tx_got.delete();
    @(negedge clock);
    proc_tx_data = b;
    proc_tx_wren = 1'b1;
    @(negedge clock);
    proc_tx_wren = 1'b0;
    tests_run++;
    if (uart_txd !== 1'b1) begin
      fails++;
      $display("FAIL tx_pop_cycle: got txd=%b, required 1", uart_txd);
    end
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clock);
      tests_run++;
      if (uart_txd !== frame_bit(b, i / CPB, 1'b0)) begin
        fails++;
        $display("FAIL tx_wave byte=%h cycle %0d: got txd=%b, required %b", b, i, uart_txd, frame_bit(b, i / CPB, 1'b0));
      end
    end
    @(negedge clock);
    tests_run++;
    if (uart_txd !== 1'b1 || tx_got.size() != 1 || tx_got[0] !== b) begin
      fails++;
      $display("FAIL tx_frame_end byte=%h: got txd=%b decoded=%0d bytes, required txd=1 and 1 byte", b, uart_txd, tx_got.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [7];
    int acc_cycle [7];
    int i, cyc;
    tx_got.delete();
    for (int k = 0; k < 5; k++) seq[k] = 8'(k + 1);
    seq[5] = 8'($urandom);
    seq[6] = 8'($urandom);
    i = 0;
    cyc = 0;
    while (i < 7 && cyc < 400) begin
      @(negedge clock);
      proc_tx_data = seq[i];
      proc_tx_wren = 1'b1;
      if (proc_tx_ready === 1'b1) begin
        acc_cycle[i] = cyc;
        i++;
      end
      cyc++;
    end
    @(negedge clock);
    proc_tx_wren = 1'b0;
    tests_run++;
    if (i != 7) begin
      fails++;
      $display("FAIL b2b_accept_all: got %0d accepted, required 7", i);
    end else begin
      // Four slots plus the byte already moved into the shifter: five land on consecutive edges.
      tests_run++;
      if (acc_cycle[4] != 4) begin
        fails++;
        $display("FAIL b2b_fill: got 5th accepted at cycle %0d, required 4", acc_cycle[4]);
      end
      tests_run++;
      if (acc_cycle[5] != FRAME + 3) begin
        fails++;
        $display("FAIL b2b_full_hold: got 6th accepted at cycle %0d, required %0d", acc_cycle[5], FRAME + 3);
      end
      tests_run++;
      if (acc_cycle[6] != 2 * FRAME + 4) begin
        fails++;
        $display("FAIL b2b_gap: got 7th accepted at cycle %0d, required %0d", acc_cycle[6], 2 * FRAME + 4);
      end
    end
    cyc = 0;
    while (tx_got.size() < 7 && cyc < 8 * (FRAME + 2)) begin
      @(negedge clock);
      cyc++;
    end
    tests_run++;
    if (tx_got.size() != 7) begin
      fails++;
      $display("FAIL b2b_tx_count: got %0d bytes on txd, required 7", tx_got.size());
    end else begin
      for (int k = 0; k < 7; k++) begin
        tests_run++;
        if (tx_got[k] !== seq[k]) begin
          fails++;
          $display("FAIL b2b_order[%0d]: got %h, required %h", k, tx_got[k], seq[k]);
        end
      end
    end
    tests_run++;
    if (tx_stop_bad != 0 || tx_par_bad != 0) begin
      fails++;
      $display("FAIL tx_framing: got %0d bad stop, %0d bad parity, required 0", tx_stop_bad, tx_par_bad);
    end
  endtask

  task automatic drain_and_check(input string tag);
    while (rx_q.size() > 0) begin
      @(negedge clock);
      tests_run++;
      if (proc_rx_valid !== 1'b1 || proc_rx_data !== rx_q[0]) begin
        fails++;
        $display("FAIL %s_pop: got valid=%b data=%h, required 1 %h", tag, proc_rx_valid, proc_rx_data, rx_q[0]);
      end
      proc_rx_rden = 1'b1;
      void'(rx_q.pop_front());
    end
    @(negedge clock);
    proc_rx_rden = 1'b0;
    tests_run++;
    if (proc_rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_empty: got valid=%b, required 0", tag, proc_rx_valid);
    end
  endtask

  task automatic test_rx_basic();
    send_rx(8'h3C, 1'b1, 1'b0);
    repeat (2) @(negedge clock);
    tests_run++;
    if (proc_rx_valid !== 1'b1 || proc_rx_data !== 8'h3C) begin
      fails++;
      $display("FAIL rx_3c: got valid=%b data=%h, required 1 3c", proc_rx_valid, proc_rx_data);
    end
    drain_and_check("rx_basic");
  endtask

  task automatic test_rx_overflow();
    for (int k = 0; k < 5; k++) send_rx(8'($urandom), 1'b1, 1'b0);
    repeat (3) @(negedge clock);
    tests_run++;
    if (ovf_pulses != exp_ovf || exp_ovf != 1) begin
      fails++;
      $display("FAIL rx_overflow: got %0d pulses, required %0d (model %0d)", ovf_pulses, 1, exp_ovf);
    end
    drain_and_check("rx_ovf");
  endtask

  task automatic test_rx_errors();
    send_rx(8'h55, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    tests_run++;
    if (err_pulses != exp_err || proc_rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL rx_bad_stop: got err=%0d valid=%b, required err=%0d valid=0", err_pulses, proc_rx_valid, exp_err);
    end
    @(negedge clock);
    uart_rxd = 1'b0;
    @(negedge clock);
    uart_rxd = 1'b1;
    repeat (20) @(negedge clock);
    tests_run++;
    if (err_pulses != exp_err || proc_rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL rx_glitch: got err=%0d valid=%b, required err=%0d valid=0", err_pulses, proc_rx_valid, exp_err);
    end
    for (int k = 0; k < 4; k++) send_rx(8'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0);
    repeat (3) @(negedge clock);
    tests_run++;
    if (err_pulses != exp_err || ovf_pulses != exp_ovf) begin
      fails++;
      $display("FAIL rx_mixed_pulses: got err=%0d ovf=%0d, required %0d %0d", err_pulses, ovf_pulses, exp_err, exp_ovf);
    end
    drain_and_check("rx_mixed");
  endtask

`ifdef SERIAL_PARITY_EN
  task automatic test_parity();
    test_tx_frame(8'h07);
    send_rx(8'h07, 1'b1, 1'b1);
    repeat (3) @(negedge clock);
    tests_run++;
    if (err_pulses != exp_err || proc_rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL rx_parity_err: got err=%0d valid=%b, required err=%0d valid=0", err_pulses, proc_rx_valid, exp_err);
    end
    send_rx(8'($urandom), 1'b1, 1'b0);
    repeat (2) @(negedge clock);
    drain_and_check("rx_parity_ok");
  endtask
`endif

  task automatic test_reset_midframe();
    int bad;
    @(negedge clock);
    proc_tx_data = 8'($urandom) & 8'hFE;
    proc_tx_wren = 1'b1;
    @(negedge clock);
    proc_tx_wren = 1'b0;
    uart_rxd = 1'b0;
    repeat (12) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if ({uart_txd, proc_tx_ready, proc_rx_valid} !== 3'b110) begin
      fails++;
      $display("FAIL reset_async: got txd/ready/valid=%b, required 110", {uart_txd, proc_tx_ready, proc_rx_valid});
    end
    uart_rxd = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clock);
      if (uart_txd !== 1'b1 || proc_rx_valid !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0 || err_pulses != exp_err || ovf_pulses != exp_ovf) begin
      fails++;
      $display("FAIL reset_abort: got %0d active cycles err=%0d ovf=%0d, required 0 %0d %0d", bad, err_pulses, ovf_pulses, exp_err, exp_ovf);
    end
  endtask

  initial begin
    reset = 1'b0;
    proc_rx_rden = 1'b0;
    proc_tx_data = 8'h00;
    proc_tx_wren = 1'b0;
    uart_rxd = 1'b1;
    test_reset();
    test_tx_frame(8'hA5);
    for (int k = 0; k < 3; k++) test_tx_frame(8'($urandom));
    test_back_to_back();
    test_rx_basic();
    test_rx_overflow();
    test_rx_errors();
`ifdef SERIAL_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
